// File: rtl/if_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : if_fetch_stage                                             |
// | Description : In-order instruction fetch with PC, credit-limited imem    |
// |               requests, instruction FIFO and branch redirect/flush.      |
// |               Optional IF_PERF_CNT_EN adds fetch/stall/flush counters.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int          c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int          c_cnt_w   = $clog2(FIFO_DEPTH + 1);
  localparam int          c_outst_w = $clog2(MAX_OUTST + 1);
  localparam logic [31:0] c_nop     = 32'h0000_0013;

  logic [31:0]          r_fetch_pc;
  logic [31:0]          r_rsp_pc;
  logic [c_outst_w-1:0] r_outst;
  logic [c_outst_w-1:0] r_discard;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [31:0]          r_mem_ins [FIFO_DEPTH];
  logic [31:0]          r_mem_pc  [FIFO_DEPTH];

  logic [31:0]          w_total;
  logic                 w_credit;
  logic                 w_req_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [c_outst_w-1:0] w_outst_next;
  logic [31:0]          w_target;
  logic                 w_unused_tgt_lsb;

  // Credit uses the registered count: a same-cycle pop frees no slot.
  assign w_total        = 32'(r_outst) + 32'(r_count);
  assign w_credit       = (w_total < 32'(FIFO_DEPTH)) && (32'(r_outst) < 32'(MAX_OUTST));
  assign imem_req_valid = !rst && !branch_taken && w_credit;
  assign imem_addr      = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_push         = imem_rsp_valid && (r_discard == '0) && !branch_taken;
  assign w_pop          = if_valid && id_ready && !branch_taken;
  assign w_target       = {branch_target[31:2], 2'b00};
  assign w_unused_tgt_lsb = ^branch_target[1:0];

  always_comb begin
    w_outst_next = r_outst;
    if (w_req_fire && !imem_rsp_valid) begin
      w_outst_next = r_outst + 1'b1;
    end else if (!w_req_fire && imem_rsp_valid) begin
      w_outst_next = r_outst - 1'b1;
    end
  end

  assign if_valid       = (r_count != '0);
  assign if_instruction = if_valid ? r_mem_ins[r_rd_ptr] : c_nop;
  assign if_pc          = if_valid ? r_mem_pc[r_rd_ptr] : r_rsp_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_outst <= w_outst_next;
      if (branch_taken) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_discard  <= w_outst_next;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (imem_rsp_valid && (r_discard != '0)) begin
          r_discard <= r_discard - 1'b1;
        end
        if (w_push) begin
          r_mem_ins[r_wr_ptr] <= imem_rsp_data;
          r_mem_pc[r_wr_ptr]  <= r_rsp_pc;
          r_wr_ptr            <= r_wr_ptr + 1'b1;
          r_rsp_pc            <= r_rsp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (w_push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (if_valid && !id_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (branch_taken) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_if_fetch_stage                                          |
// | Description : Randomised bench for if_fetch_stage with an in-order imem  |
// |               model and a path/epoch-based instruction stream model.     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam int          MAXO   = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stimulus knobs (percent, except p_rst which is per mille)
  int p_ready, p_idr, p_rsp, p_br, p_rst, lat_max;
  logic        force_br, force_rst;
  logic [31:0] force_tgt;

  // Model: imem in-flight queue tagged with the path epoch it was fetched on
  logic [31:0] q_addr[$];
  int          q_epoch[$];
  int          q_due[$];
  int          m_epoch, m_buf;
  logic [31:0] m_fetch_pc, m_head_pc;
  logic [31:0] m_fetched, m_stall, m_flush;

  logic [31:0] acc_log[$];
  logic [31:0] con_log[$];
  logic        obs_if_valid, obs_req_valid;
  logic [31:0] obs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else t = $urandom();
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string name, input logic [31:0] lg[$], input int idx,
                         input logic [31:0] exp);
    if (idx >= lg.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no entry %0d, expected %h", name, idx, exp);
    end else begin
      chk(name, lg[idx], exp);
    end
  endtask

  task automatic step();
    logic exp_req, fire, pop, fresh, was_valid;
    @(negedge clk);
    rst            = force_rst || ($urandom_range(0, 999) < p_rst);
    branch_taken   = !rst && (force_br || ($urandom_range(0, 99) < p_br));
    branch_target  = force_br ? force_tgt : rand_target();
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    id_ready       = ($urandom_range(0, 99) < p_idr);
    imem_rsp_valid = !rst && (q_due.size() > 0) && (q_due[0] <= cyc) &&
                     ($urandom_range(0, 99) < p_rsp);
    imem_rsp_data  = imem_rsp_valid ? mem_word(q_addr[0]) : $urandom();
    #1;
    obs_if_valid  = if_valid;
    obs_req_valid = imem_req_valid;
    obs_addr      = imem_addr;
    was_valid     = (m_buf > 0);
    if (rst) begin
      chk("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
    end else begin
      exp_req = !branch_taken && (q_addr.size() + m_buf < DEPTH) && (q_addr.size() < MAXO);
      chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, was_valid});
      if (was_valid) begin
        chk("if_pc", if_pc, m_head_pc);
        chk("if_instruction", if_instruction, mem_word(m_head_pc));
      end else begin
        chk("if_instruction_nop", if_instruction, 32'h0000_0013);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_flush", perf_flush, m_flush);
`endif
    end
    fire = imem_req_valid && imem_req_ready;
    pop  = was_valid && id_ready;
    if (rst) begin
      q_addr.delete(); q_epoch.delete(); q_due.delete();
      m_buf = 0; m_epoch++;
      m_fetch_pc = RST_PC; m_head_pc = RST_PC;
      m_fetched = 0; m_stall = 0; m_flush = 0;
    end else begin
      fresh = 1'b0;
      if (imem_rsp_valid) begin
        fresh = (q_epoch[0] == m_epoch);
        void'(q_addr.pop_front()); void'(q_epoch.pop_front()); void'(q_due.pop_front());
      end
      if (fire) begin
        q_addr.push_back(imem_addr);
        q_epoch.push_back(m_epoch);
        q_due.push_back(cyc + 1 + int'($urandom_range(0, lat_max)));
        acc_log.push_back(imem_addr);
      end
      if (was_valid && !id_ready) m_stall++;
      if (branch_taken) begin
        m_epoch++;
        m_buf      = 0;
        m_fetch_pc = {branch_target[31:2], 2'b00};
        m_head_pc  = m_fetch_pc;
        m_flush++;
      end else begin
        if (fire) m_fetch_pc += 32'd4;
        if (pop) begin
          con_log.push_back(if_pc);
          m_buf--;
          m_head_pc += 32'd4;
        end
        if (fresh) begin
          m_buf++;
          m_fetched++;
        end
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    force_br  = 1'b1;
    force_tgt = tgt;
    step();
    force_br  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_target = '0; imem_req_ready = 1'b0;
    id_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    force_br = 1'b0; force_rst = 1'b0; force_tgt = '0;
    m_epoch = 0; m_buf = 0; m_fetch_pc = RST_PC; m_head_pc = RST_PC;
    m_fetched = 0; m_stall = 0; m_flush = 0;
    p_ready = 100; p_idr = 100; p_rsp = 100; p_br = 0; p_rst = 0; lat_max = 0;

    force_rst = 1'b1;
    repeat (2) step();
    force_rst = 1'b0;

    // Streaming from reset with single-cycle memory
    acc_log.delete(); con_log.delete();
    repeat (12) step();
    chk_log("t1_addr0", acc_log, 0, 32'h0);
    chk_log("t1_addr1", acc_log, 1, 32'h4);
    chk_log("t1_addr2", acc_log, 2, 32'h8);
    chk_log("t1_pc0", con_log, 0, 32'h0);
    chk_log("t1_pc1", con_log, 1, 32'h4);
    chk_log("t1_pc2", con_log, 2, 32'h8);

    // Decode back-pressure fills the buffer and throttles requests
    p_idr = 0;
    repeat (10) step();
    chk("t2_req_valid_full", {31'd0, obs_req_valid}, 32'd0);
    chk("t2_if_valid_full", {31'd0, obs_if_valid}, 32'd1);
    p_idr = 100;
    repeat (10) step();

    // Two requests in flight, then redirect: stale words must be dropped
    p_rsp = 0;
    repeat (6) step();
    redirect(32'h0000_0100);
    p_rsp = 100;
    con_log.delete();
    repeat (10) step();
    chk_log("t3_pc_after_flush", con_log, 0, 32'h0000_0100);

    // Unaligned target is masked
    acc_log.delete(); con_log.delete();
    redirect(32'h0000_0203);
    repeat (8) step();
    chk_log("t4_addr", acc_log, 0, 32'h0000_0200);
    chk_log("t4_pc", con_log, 0, 32'h0000_0200);

    // PC wraps at the top of the address space
    acc_log.delete(); con_log.delete();
    redirect(32'hFFFF_FFFC);
    repeat (8) step();
    chk_log("t5_addr_top", acc_log, 0, 32'hFFFF_FFFC);
    chk_log("t5_addr_wrap", acc_log, 1, 32'h0000_0000);
    chk_log("t5_pc_wrap", con_log, 1, 32'h0000_0000);

    // Reset with a full buffer
    p_idr = 0;
    repeat (8) step();
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    step();
    chk("t6_if_valid_after_rst", {31'd0, obs_if_valid}, 32'd0);
    chk("t6_addr_after_rst", obs_addr, RST_PC);

    // Randomised traffic
    p_ready = 70; p_idr = 60; p_rsp = 70; lat_max = 3; p_br = 5; p_rst = 5;
    repeat (3000) step();
    p_br = 0; p_rst = 0; p_idr = 100; p_rsp = 100;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
